pipe_ctrl_n: RTL
================

Name: pipe_ctrl_n

Overview:
Parametrised pipeline control unit for the openMIPS core, generalising the fixed 6-bit stall controller.
- Merges NUM_REQ stall requests, each bound to a configurable stage, into a per-stage hold vector.
- Adds exception flush sequencing with a latched redirect PC.
- Adds a stall watchdog and a saturating stall-cycle counter.
- Sits beside pc_reg and the inter-stage registers; its stall_o and flush_o drive them directly.

Parameters:
NUM_STAGES, 6, number of pipeline stages (0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb).
NUM_REQ, 3, number of stall request sources.
REQ_STAGE, {4'd4,4'd3,4'd2}, packed NUM_REQ×4-bit field; slice i is the stage index that stallreq_i[i] freezes up to, inclusive.
ADDR_W, 32, PC width.
FLUSH_CYCLES, 1, cycles flush_o is held high per exception, 1..15.
WDOG_W, 8, watchdog counter width.
WDOG_LIMIT, 200, consecutive stalled cycles that trigger a timeout; must be less than 2^WDOG_W.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stallreq_i  in  NUM_REQ  stall requests; bit i is bound to stage REQ_STAGE[i]
excp_req_i  in  1  exception request, single-cycle pulse
excp_pc_i  in  ADDR_W  handler address, valid when excp_req_i=1
stall_o  out  NUM_STAGES  hold vector; bit k=1 means stage k holds its register
flush_o  out  1  clears all inter-stage registers
new_pc_o  out  ADDR_W  redirect target for pc_reg, valid while flush_o=1
state_o  out  2  registered FSM state: 0=RUN, 1=STALL, 2=FLUSH
wdog_timeout_o  out  1  sticky watchdog flag
stall_cycles_o  out  32  saturating count of cycles with stall_o[0]=1

Behaviour:
- Reset is the only asynchronous-free clear; all flops update on posedge clk only.
- Reset values: state=RUN, flush_o=0, new_pc_o=0, flush counter=0, watchdog counter=0, wdog_timeout_o=0, stall_cycles_o=0.
- stall_o during rst=1 is all zeros.
- Stall merge (combinational, zero latency, matches current openMIPS timing):
  - s_max = largest REQ_STAGE[i] over all asserted stallreq_i[i].
  - stall_o[k] = 1 for k ≤ s_max, 0 otherwise.
  - No request asserted → stall_o = 0.
  - REQ_STAGE values ≥ NUM_STAGES clamp to NUM_STAGES-1.
  - The stage s_max+1 register inserts a bubble; that is the stage register's job, not this block's.
- Exception capture cycle (excp_req_i=1):
  - stall_o = all ones, overriding requests.
  - new_pc_o ← excp_pc_i at the clock edge.
  - flush counter ← FLUSH_CYCLES.
  - Next state = FLUSH.
- FLUSH state:
  - flush_o=1 and stall_o=0; stall requests are ignored.
  - Counter decrements each cycle; exit when it reaches 1.
  - Exit state: STALL if any stallreq_i is asserted that cycle, else RUN.
- excp_req_i during FLUSH: relatch new_pc_o, reload counter to FLUSH_CYCLES, remain in FLUSH. The new exception wins; there is no queueing.
- RUN/STALL: next state = STALL if stall_o≠0, else RUN. state_o is informational and lags stall_o by one cycle.
- Watchdog:
  - Increments on every cycle stall_o≠0 outside FLUSH.
  - Clears on any cycle with stall_o=0 or in FLUSH.
  - When the counter equals WDOG_LIMIT-1 and another stalled cycle occurs, wdog_timeout_o ← 1.
  - wdog_timeout_o stays set until rst. The counter saturates and does not wrap.
- stall_cycles_o: +1 per cycle with stall_o[0]=1, including the exception capture cycle; saturates at 32'hFFFFFFFF.
- rst asserted mid-flush or mid-stall: all state returns to reset values on that edge; flush_o drops the next cycle.

Decomposition:
- Shared package/define.v: state encodings (PCTRL_RUN/STALL/FLUSH), stage index constants (STG_PC..STG_WB), default REQ_STAGE.
- One natural sub-module, pctrl_stall_merge: purely combinational, maps stallreq_i and REQ_STAGE to the thermometer vector stall_o.
- FSM, watchdog and counters stay in pipe_ctrl_n.

Test Plan:
1. Defaults, stallreq_i=3'b001 (id) → stall_o=6'b000111; 3'b010 → 6'b001111; 3'b101 → 6'b011111; 0 → 6'b000000; state_o=1 the cycle after each nonzero case.
2. excp_req_i=1 with excp_pc_i=32'h0000_0040, FLUSH_CYCLES=1 → same cycle stall_o=6'b111111; next cycle flush_o=1, new_pc_o=32'h40, stall_o=0, state_o=2; following cycle flush_o=0.
3. FLUSH_CYCLES=3, second excp_req_i (pc=32'h80) in flush cycle 2 → flush_o held for 2+3=5 cycles total; new_pc_o=32'h80 from the cycle after the second pulse.
4. WDOG_LIMIT=4, stallreq_i=3'b010 held 4 cycles → wdog_timeout_o=1 after the 4th edge; drop requests → flag stays 1 until rst.
5. stallreq_i=3'b100 for 10 cycles, then rst=1 for one cycle → stall_cycles_o reads 10 before reset, 0 after; flush_o=0, state_o=0.
6. stallreq_i=3'b001 asserted during a flush → stall_o=0 while flush_o=1; on exit state_o=1 and stall_o=6'b000111.

Source files
------------

// File: rtl/pipe_ctrl_n_pkg.sv
// Shared definitions for the pipeline control unit: FSM encoding, stage
// indices and the default stall-request binding.
package pipe_ctrl_n_pkg;

    typedef enum logic [1:0] {
        PCTRL_RUN   = 2'd0,
        PCTRL_STALL = 2'd1,
        PCTRL_FLUSH = 2'd2
    } pctrl_state_e;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    // slice 0 -> id, slice 1 -> ex, slice 2 -> mem
    localparam logic [11:0] PCTRL_DEF_REQ_STAGE = {4'd4, 4'd3, 4'd2};

    // Stage indices past the last stage freeze the whole pipe.
    function automatic int clamp_stage(input logic [3:0] s, input int n);
        int v;
        v = int'(s);
        return (v >= n) ? n - 1 : v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_n_stall_merge.sv
// Combinational merge of stall requests into a thermometer hold vector:
// every stage up to the deepest requested stage holds.
module pctrl_stall_merge
    import pipe_ctrl_n_pkg::*;
#(
    parameter int                       NUM_STAGES = 6,
    parameter int                       NUM_REQ    = 3,
    parameter logic [NUM_REQ*4-1:0]     REQ_STAGE  = PCTRL_DEF_REQ_STAGE
) (
    input  logic [NUM_REQ-1:0]    stallreq_i,
    output logic [NUM_STAGES-1:0] stall_o
);

    int   smax;
    logic any_req;

    // Find the deepest requested stage, then fill ones from stage 0 up to it.
    always_comb begin
        smax    = 0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stallreq_i[i]) begin
                any_req = 1'b1;
                if (clamp_stage(REQ_STAGE[i*4 +: 4], NUM_STAGES) > smax)
                    smax = clamp_stage(REQ_STAGE[i*4 +: 4], NUM_STAGES);
            end
        end
        stall_o = '0;
        for (int k = 0; k < NUM_STAGES; k++)
            stall_o[k] = any_req && (k <= smax);
    end

endmodule

// File: rtl/pipe_ctrl_n.sv
// Pipeline control unit: stall merge, exception flush sequencing with a
// latched redirect PC, stall watchdog and saturating stall-cycle counter.
module pipe_ctrl_n
    import pipe_ctrl_n_pkg::*;
#(
    parameter int                   NUM_STAGES   = 6,
    parameter int                   NUM_REQ      = 3,
    parameter logic [NUM_REQ*4-1:0] REQ_STAGE    = PCTRL_DEF_REQ_STAGE,
    parameter int                   ADDR_W       = 32,
    parameter int                   FLUSH_CYCLES = 1,
    parameter int                   WDOG_W       = 8,
    parameter int                   WDOG_LIMIT   = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    stallreq_i,
    input  logic                  excp_req_i,
    input  logic [ADDR_W-1:0]     excp_pc_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic                  flush_o,
    output logic [ADDR_W-1:0]     new_pc_o,
    output logic [1:0]            state_o,
    output logic                  wdog_timeout_o,
    output logic [31:0]           stall_cycles_o
);

    localparam logic [3:0]        FLUSH_INIT = 4'(FLUSH_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST  = WDOG_W'(WDOG_LIMIT - 1);
    localparam logic [WDOG_W-1:0] WDOG_SAT   = WDOG_W'(WDOG_LIMIT);

    logic [NUM_STAGES-1:0] merge_stall;
    logic [NUM_STAGES-1:0] stall_vec;
    logic                  stalled;

    pctrl_state_e      state_q, state_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic [ADDR_W-1:0] new_pc_q, new_pc_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       scyc_q, scyc_d;

    pctrl_stall_merge #(
        .NUM_STAGES (NUM_STAGES),
        .NUM_REQ    (NUM_REQ),
        .REQ_STAGE  (REQ_STAGE)
    ) u_merge (
        .stallreq_i (stallreq_i),
        .stall_o    (merge_stall)
    );

    // Hold vector: exception freezes everything, flush releases everything.
    always_comb begin
        stall_vec = '0;
        if (rst)
            stall_vec = '0;
        else if (excp_req_i)
            stall_vec = '1;
        else if (state_q == PCTRL_FLUSH)
            stall_vec = '0;
        else
            stall_vec = merge_stall;
    end

    // FSM next state, flush counter and redirect PC; a new exception always wins.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        new_pc_d = new_pc_q;
        case (state_q)
            PCTRL_FLUSH: begin
                if (fcnt_q <= 4'd1) begin
                    state_d = (|stallreq_i) ? PCTRL_STALL : PCTRL_RUN;
                    fcnt_d  = 4'd0;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: state_d = (|stall_vec) ? PCTRL_STALL : PCTRL_RUN;
        endcase
        if (excp_req_i) begin
            state_d  = PCTRL_FLUSH;
            fcnt_d   = FLUSH_INIT;
            new_pc_d = excp_pc_i;
        end
    end

    // Watchdog and stall-cycle counter; both saturate instead of wrapping.
    always_comb begin
        stalled   = (|stall_vec) && (state_q != PCTRL_FLUSH);
        wdog_d    = '0;
        timeout_d = timeout_q;
        scyc_d    = scyc_q;
        if (stalled) begin
            wdog_d    = (wdog_q == WDOG_SAT) ? wdog_q : wdog_q + 1'b1;
            timeout_d = timeout_q | (wdog_q == WDOG_LAST);
        end
        if (stall_vec[0] && scyc_q != 32'hFFFF_FFFF)
            scyc_d = scyc_q + 32'd1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PCTRL_RUN;
            fcnt_q    <= '0;
            new_pc_q  <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            scyc_q    <= '0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            new_pc_q  <= new_pc_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            scyc_q    <= scyc_d;
        end
    end

    assign stall_o        = stall_vec;
    assign flush_o        = (state_q == PCTRL_FLUSH);
    assign new_pc_o       = new_pc_q;
    assign state_o        = state_q;
    assign wdog_timeout_o = timeout_q;
    assign stall_cycles_o = scyc_q;

endmodule
